johnson_counter_param: RTL
==========================

# johnson_counter_param

Parametrised twisted-ring counter for the lab display path. It counts in Johnson mode (period 2N) or one-hot ring mode (period N), up or down, with enable, prescaler and synchronous index load. It drives the raw code, a binary state index and a hex seven-segment pattern of that index. It replaces the fixed 3-bit Johnson counter on the board's seven-segment output.

## Interface
- N, default 3: counter width; legal range 2..8, so the index always fits one hex digit.
- DIV, default 1: prescaler ratio; the counter steps once per DIV enabled cycles; DIV ≥ 1.
- inClk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  count enable; gates the prescaler.
- dir  in  1  0 = up, 1 = down.
- mode  in  1  0 = Johnson, 1 = ring (one-hot).
- ld  in  1  synchronous load strobe.
- ld_idx  in  4  index to load.
- cntr  out  N  counter code.
- idx  out  4  state index, 0..P-1, where P = 2N (Johnson) or N (ring).
- Seven_Seg  out  8  bit 7 = dp, bits 6..0 = g,f,e,d,c,b,a; active-high.
- wrap  out  1  one-cycle pulse on index wrap.

## Operation
- Johnson up step: cntr ← {cntr[N-2:0], ~cntr[N-1]}. Sequence for N=3, index 0..5: 000, 001, 011, 111, 110, 100.
- Johnson down step: cntr ← {~cntr[0], cntr[N-1:1]}. This is the exact reverse sequence.
- Ring up step: rotate left. Ring down step: rotate right. Index i corresponds to code 1<<i.
- idx and cntr are registered together and always stay consistent.
  - Up step: idx ← (idx==P-1) ? 0 : idx+1.
  - Down step: idx ← (idx==0) ? P-1 : idx-1.
- mode_q holds the registered copy of mode.
- Action priority per edge, highest first:
  1. Mode change (mode ≠ mode_q): mode_q ← mode; load index 0 of the new mode (Johnson: all zeros; ring: 0…01); prescaler ← 0; no step.
  2. ld: load ld_idx and its code; prescaler ← 0. If ld_idx ≥ P, load index 0 instead.
  3. Step: when en=1 and prescaler==DIV-1, step in direction dir and set prescaler ← 0.
  4. Prescale: when en=1 and prescaler<DIV-1, prescaler ← prescaler+1.
  5. Otherwise hold. en=0 freezes the prescaler value.
- wrap: registered and high for exactly one cycle after a step that moves the index P-1→0 (up) or 0→P-1 (down). Loads and mode changes never assert wrap.
- Seven_Seg[6:0] is a combinational decode of registered idx:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Seven_Seg[7] (dp) = mode_q; the decimal point is lit in ring mode.

## Timing
- Reset (rst=0, asynchronous) values: cntr=0, idx=0, mode_q=0, prescaler=0, wrap=0, Seven_Seg=8'h3F.
- Reset assertion mid-count takes effect immediately, without waiting for a clock edge.
- First edge after release:
  - mode=1: the mode-change rule applies, giving cntr=0…01, idx=0, Seven_Seg=8'hBF.
  - mode=0: normal stepping applies.
- Step latency: cntr, idx and Seven_Seg update on the same edge that satisfies the step condition.
- With DIV=1 and en held high, the counter steps every cycle. With DIV=k, steps occur on every k-th enabled edge.
- ld or a mode change takes effect on that edge. The next step comes DIV enabled edges later.
- dir may change on any cycle; the next step follows the new direction with no extra latency.
- ld and mode change in the same cycle: the mode change wins and ld is ignored.
- ld and step condition in the same cycle: ld wins.

## Test plan
- N=3, DIV=1, mode=0, dir=0, en=1, release reset: cntr runs 000,001,011,111,110,100,000; Seven_Seg runs 3F,06,5B,4F,66,6D,3F; wrap pulses once, on the cycle after the 100→000 edge.
- Same setup with dir=1 from reset: cntr runs 000,100,110,111,011,001,000; idx runs 0,5,4,3,2,1,0; wrap pulses right after the 0→5 step.
- mode=1 at reset release, N=3: cntr=001 with dp=1 (Seven_Seg=BF), then 010,100,001; toggling mode to 0 mid-count gives cntr=000, idx=0 on the next edge with no wrap pulse.
- DIV=3, en toggles 1,1,0,1 then stays at 1: first step occurs on the third enabled edge; en=0 holds cntr and prescaler; steps then continue every 3 cycles.
- ld=1 with ld_idx=4 in Johnson mode, N=3: cntr=110, Seven_Seg=66. ld_idx=7 gives index 0, cntr=000. ld asserted together with a mode change: ld is ignored.
- Assert rst=0 between clock edges mid-count: outputs go to reset values immediately (cntr=0, Seven_Seg=3F, wrap=0).

Source files
------------

// File: rtl/johnson_counter_param.sv
// Parametrised Johnson / one-hot ring counter with prescaler, load, index and hex 7-seg decode.
// Latency: code, index and segments update on the stepping edge; wrap is a registered 1-cycle pulse; no backpressure.
module johnson_counter_param #(
    parameter int N   = 3,
    parameter int DIV = 1
) (
    input  logic         inClk,
    input  logic         rst,
    input  logic         en,
    input  logic         dir,
    input  logic         mode,
    input  logic         ld,
    input  logic [3:0]   ld_idx,
    output logic [N-1:0] cntr,
    output logic [3:0]   idx,
    output logic [7:0]   Seven_Seg,
    output logic         wrap
);

    localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [3:0]    J_LAST   = 4'(2 * N - 1);
    localparam logic [3:0]    R_LAST   = 4'(N - 1);

    logic          mode_q;
    logic [PW-1:0] pre;

    logic [N-1:0]  cntr_n;
    logic [3:0]    idx_n;
    logic          mode_n;
    logic [PW-1:0] pre_n;
    logic          wrap_n;
    logic [3:0]    last;
    logic [6:0]    seg7;

    // Johnson index i < N has the low i bits set; i >= N has the top 2N-i bits set.
    function automatic logic [N-1:0] code_of(input logic ring, input logic [3:0] i);
        logic [N-1:0] c;
        int           k;
        c = '0;
        k = int'(i);
        for (int b = 0; b < N; b++) begin
            if (ring)
                c[b] = (b == k);
            else if (k < N)
                c[b] = (b < k);
            else
                c[b] = (b >= k - N);
        end
        return c;
    endfunction

    always_comb begin
        last   = mode_q ? R_LAST : J_LAST;
        cntr_n = cntr;
        idx_n  = idx;
        mode_n = mode_q;
        pre_n  = pre;
        wrap_n = 1'b0;
        if (mode != mode_q) begin
            mode_n = mode;
            idx_n  = 4'd0;
            cntr_n = code_of(mode, 4'd0);
            pre_n  = '0;
        end else if (ld) begin
            idx_n  = (ld_idx > last) ? 4'd0 : ld_idx;
            cntr_n = code_of(mode_q, idx_n);
            pre_n  = '0;
        end else if (en) begin
            if (pre == PRE_LAST) begin
                pre_n = '0;
                if (!dir) begin
                    cntr_n = mode_q ? {cntr[N-2:0], cntr[N-1]} : {cntr[N-2:0], ~cntr[N-1]};
                    idx_n  = (idx == last) ? 4'd0 : idx + 4'd1;
                    wrap_n = (idx == last);
                end else begin
                    cntr_n = mode_q ? {cntr[0], cntr[N-1:1]} : {~cntr[0], cntr[N-1:1]};
                    idx_n  = (idx == 4'd0) ? last : idx - 4'd1;
                    wrap_n = (idx == 4'd0);
                end
            end else begin
                pre_n = pre + 1'b1;
            end
        end
    end

    always_ff @(posedge inClk or negedge rst) begin
        if (!rst) begin
            cntr   <= '0;
            idx    <= 4'd0;
            mode_q <= 1'b0;
            pre    <= '0;
            wrap   <= 1'b0;
        end else begin
            cntr   <= cntr_n;
            idx    <= idx_n;
            mode_q <= mode_n;
            pre    <= pre_n;
            wrap   <= wrap_n;
        end
    end

    always_comb begin
        seg7 = 7'h3F;
        case (idx)
            4'h0: seg7 = 7'h3F;
            4'h1: seg7 = 7'h06;
            4'h2: seg7 = 7'h5B;
            4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;
            4'h5: seg7 = 7'h6D;
            4'h6: seg7 = 7'h7D;
            4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;
            4'h9: seg7 = 7'h6F;
            4'hA: seg7 = 7'h77;
            4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;
            4'hD: seg7 = 7'h5E;
            4'hE: seg7 = 7'h79;
            4'hF: seg7 = 7'h71;
            default: seg7 = 7'h3F;
        endcase
    end

    // Decimal point marks ring mode.
    assign Seven_Seg = {mode_q, seg7};

endmodule
